// File: rtl/alu_seq.sv
// alu_seq: single-cycle ALU with a bit-serial shifter taking one cycle per shifted position
module alu_seq #(
  parameter int WIDTH = 8,
  parameter int CNT_W = $clog2(WIDTH)
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             start_i,
  input  logic [3:0]       ALUOp_i,
  input  logic [WIDTH-1:0] rs_i,
  input  logic [WIDTH-1:0] op2_i,
  input  logic             carry_i,
  input  logic [CNT_W-1:0] count_i,
  output logic             ready_o,
  output logic             valid_o,
  output logic [WIDTH-1:0] res_o,
  output logic             carry_o,
  output logic             zero_o,
  output logic             illegal_o
);
  typedef enum logic {IDLE, SHIFT} state_t;
  state_t           state;
  logic [WIDTH-1:0] sh;
  logic [1:0]       sop_q;
  logic [CNT_W-1:0] cnt;
  logic [WIDTH:0]   a, b, alu, stp, out;
  logic [WIDTH-1:0] src;
  logic [1:0]       sop;
  logic             go, is_sh, done;
  assign ready_o = state == IDLE;
  assign go      = start_i & ready_o;
  assign is_sh   = ALUOp_i[3:2] == 2'b10 && count_i != '0;
  // one-cycle result at WIDTH+1 bits; shifts by zero pass rs through, unused codes give zero
  always_comb begin
    a = {1'b0, rs_i};
    b = {1'b0, op2_i};
    case (ALUOp_i)
      4'h0:                alu = a + b;
      4'h1:                alu = a + b + {{WIDTH{1'b0}}, carry_i};
      4'h2:                alu = a - b;
      4'h3:                alu = a - b - {{WIDTH{1'b0}}, carry_i};
      4'h4:                alu = a & b;
      4'h5:                alu = a | b;
      4'h6:                alu = a ^ b;
      4'h7:                alu = a & ~b;
      4'h8, 4'h9, 4'hA, 4'hB: alu = a;
      default:             alu = '0;
    endcase
  end
  // single shift step {bit moved out, new value}: first step from rs_i, later steps from the shift register
  always_comb begin
    src  = state == IDLE ? rs_i : sh;
    sop  = state == IDLE ? ALUOp_i[1:0] : sop_q;
    stp  = sop == 2'd0 ? {src[WIDTH-1], src << 1} :
           sop == 2'd1 ? {src[0], src >> 1} :
           sop == 2'd2 ? {src[WIDTH-1], src[WIDTH-2:0], src[WIDTH-1]} :
                         {src[0], src[0], src[WIDTH-1:1]};
    out  = (state == SHIFT || is_sh) ? stp : alu;
    done = state == IDLE ? start_i & (!is_sh || count_i == CNT_W'(1)) : cnt == CNT_W'(1);
  end
  // control, shifter state and registered results
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state     <= IDLE;
      sh        <= '0;
      sop_q     <= '0;
      cnt       <= '0;
      valid_o   <= 1'b0;
      illegal_o <= 1'b0;
      res_o     <= '0;
      carry_o   <= 1'b0;
      zero_o    <= 1'b1;
    end else begin
      valid_o   <= done;
      illegal_o <= go & ALUOp_i[3] & ALUOp_i[2];
      if (done) begin
        res_o   <= out[WIDTH-1:0];
        carry_o <= out[WIDTH];
        zero_o  <= out[WIDTH-1:0] == '0;
      end
      if (go && is_sh) begin
        sh    <= stp[WIDTH-1:0];
        sop_q <= ALUOp_i[1:0];
        cnt   <= count_i - CNT_W'(1);
        if (count_i != CNT_W'(1)) state <= SHIFT;
      end else if (state == SHIFT) begin
        sh  <= stp[WIDTH-1:0];
        cnt <= cnt - CNT_W'(1);
        if (done) state <= IDLE;
      end
    end
  end
endmodule

// File: tb/tb_alu_seq.sv
// tb_alu_seq: directed and random checks of alu_seq against an arithmetic reference model
module tb_alu_seq;
  localparam int W = 8;
  localparam int CW = 3;
  logic clk = 1'b0, rst_n = 1'b0;
  logic start = 1'b0, cin = 1'b0;
  logic [3:0] op_i = '0;
  logic [W-1:0] rs = '0, op2 = '0;
  logic [CW-1:0] cnt = '0;
  logic ready_o, valid_o, carry_o, zero_o, illegal_o;
  logic [W-1:0] res_o;
  logic start_h = 1'b0, cin_h = 1'b0;
  logic [3:0] op_h = '0;
  logic [15:0] rs_h = '0, op2_h = '0;
  logic [3:0] cnt_h = '0;
  logic ready_h, valid_h, carry_h, zero_h, illegal_h;
  logic [15:0] res_h;
  int errors = 0, checks = 0;

  always #5 clk = ~clk;

  alu_seq #(.WIDTH(W)) dut (
    .clk_i(clk), .rst_ni(rst_n), .start_i(start), .ALUOp_i(op_i), .rs_i(rs), .op2_i(op2),
    .carry_i(cin), .count_i(cnt), .ready_o(ready_o), .valid_o(valid_o), .res_o(res_o),
    .carry_o(carry_o), .zero_o(zero_o), .illegal_o(illegal_o)
  );

  alu_seq #(.WIDTH(16)) dut16 (
    .clk_i(clk), .rst_ni(rst_n), .start_i(start_h), .ALUOp_i(op_h), .rs_i(rs_h), .op2_i(op2_h),
    .carry_i(cin_h), .count_i(cnt_h), .ready_o(ready_h), .valid_o(valid_h), .res_o(res_h),
    .carry_o(carry_h), .zero_o(zero_h), .illegal_o(illegal_h)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // reference: {illegal, carry, result} from plain integer arithmetic
  function automatic logic [W+1:0] model(input logic [3:0] op, input longint a, input longint b,
                                         input longint c, input longint k);
    longint m, r, cy;
    logic ill;
    m = (64'd1 << W) - 1;
    cy = 0;
    ill = 1'b0;
    case (op)
      4'h0: r = a + b;
      4'h1: r = a + b + c;
      4'h2: r = a - b;
      4'h3: r = a - b - c;
      4'h4: r = a & b;
      4'h5: r = a | b;
      4'h6: r = a ^ b;
      4'h7: r = a & ~b & m;
      4'h8: begin r = (a << k) & m; cy = k != 0 ? (a >> (W - k)) & 1 : 0; end
      4'h9: begin r = a >> k; cy = k != 0 ? (a >> (k - 1)) & 1 : 0; end
      4'hA: begin r = ((a << k) | (a >> (W - k))) & m; cy = k != 0 ? r & 1 : 0; end
      4'hB: begin r = ((a >> k) | (a << (W - k))) & m; cy = k != 0 ? (r >> (W - 1)) & 1 : 0; end
      default: begin r = 0; ill = 1'b1; end
    endcase
    if (op < 4) begin
      cy = (r < 0 || r > m) ? 1 : 0;
      r = r & m;
    end
    return {ill, cy[0], r[W-1:0]};
  endfunction

  // issue one op at the current post-edge point; while busy, throw junk starts that must be ignored
  task automatic do_op(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic c, input logic [CW-1:0] k);
    logic [W+1:0] e;
    logic [W-1:0] held;
    int lat;
    e = model(op, longint'(a), longint'(b), longint'(c), longint'(k));
    held = res_o;
    lat = (op[3:2] == 2'b10 && k >= 2) ? int'(k) : 1;
    op_i = op; rs = a; op2 = b; cin = c; cnt = k; start = 1'b1;
    chk("ready_at_accept", ready_o, 1);
    @(posedge clk); #1;
    for (int i = 1; i < lat; i++) begin
      chk("busy_ready", ready_o, 0);
      chk("busy_valid", valid_o, 0);
      chk("busy_illegal", illegal_o, 0);
      chk("busy_res_held", res_o, held);
      op_i = 4'($urandom); rs = W'($urandom); op2 = W'($urandom);
      cin = 1'($urandom); cnt = CW'($urandom); start = 1'b1;
      @(posedge clk); #1;
    end
    start = 1'b0;
    chk("done_valid", valid_o, 1);
    chk("done_ready", ready_o, 1);
    chk("done_res", res_o, e[W-1:0]);
    chk("done_carry", carry_o, e[W]);
    chk("done_zero", zero_o, e[W-1:0] == '0);
    chk("done_illegal", illegal_o, e[W+1]);
  endtask

  initial begin
    logic [15:0] pa, pb;
    #13;
    chk("rst_ready", ready_o, 1);
    chk("rst_valid", valid_o, 0);
    chk("rst_illegal", illegal_o, 0);
    chk("rst_res", res_o, 0);
    chk("rst_carry", carry_o, 0);
    chk("rst_zero", zero_o, 1);
    rst_n = 1'b1;
    do_op(4'h0, 8'hF0, 8'h20, 1'b0, 3'd0);
    chk("add_res_const", res_o, 8'h10);
    chk("add_carry_const", carry_o, 1);
    chk("add_zero_const", zero_o, 0);
    do_op(4'h3, 8'h05, 8'h05, 1'b1, 3'd0);
    chk("subc_res_const", res_o, 8'hFF);
    chk("subc_carry_const", carry_o, 1);
    do_op(4'h2, 8'h05, 8'h05, 1'b0, 3'd0);
    chk("sub_res_const", res_o, 8'h00);
    chk("sub_zero_const", zero_o, 1);
    do_op(4'h8, 8'h81, 8'h00, 1'b0, 3'd3);
    chk("shl_res_const", res_o, 8'h08);
    chk("shl_carry_const", carry_o, 0);
    do_op(4'hB, 8'h01, 8'h00, 1'b0, 3'd1);
    chk("ror_res_const", res_o, 8'h80);
    chk("ror_carry_const", carry_o, 1);
    do_op(4'hA, 8'h5A, 8'h00, 1'b0, 3'd7);
    do_op(4'h9, 8'hC3, 8'h00, 1'b0, 3'd0);
    do_op(4'hD, 8'h77, 8'h11, 1'b1, 3'd2);
    for (int n = 0; n < 200; n++)
      do_op(4'($urandom_range(0, 15)), W'($urandom), W'($urandom), 1'($urandom), CW'($urandom));
    op_i = 4'h8; rs = 8'hFF; cnt = 3'd5; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    chk("abort_ready", ready_o, 1);
    chk("abort_valid", valid_o, 0);
    chk("abort_res", res_o, 0);
    chk("abort_carry", carry_o, 0);
    chk("abort_zero", zero_o, 1);
    #2 rst_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1;
      chk("abort_no_valid", valid_o, 0);
      chk("abort_idle", ready_o, 1);
    end
    op_h = 4'hE; rs_h = 16'h1234; op2_h = 16'h00FF; start_h = 1'b1;
    @(posedge clk); #1;
    chk("w16_ill_valid", valid_h, 1);
    chk("w16_ill_pulse", illegal_h, 1);
    chk("w16_ill_res", res_h, 0);
    chk("w16_ill_zero", zero_h, 1);
    op_h = 4'h4;
    for (int i = 0; i < 5; i++) begin
      pa = 16'($urandom); pb = 16'($urandom);
      rs_h = pa; op2_h = pb;
      @(posedge clk); #1;
      chk("w16_b2b_valid", valid_h, 1);
      chk("w16_b2b_illegal", illegal_h, 0);
      chk("w16_b2b_res", res_h, pa & pb);
      chk("w16_b2b_ready", ready_h, 1);
    end
    start_h = 1'b0;
    @(posedge clk); #1;
    chk("w16_idle_valid", valid_h, 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
